// File: rtl/stage_ram_writer.sv
// Update engine for one trie stage: serialises write / nexthop-RMW / range-clear
// commands onto the stage memory write port. Range clear exists only with STAGE_RAM_WRITER_CLEAR_EN.
module stage_ram_writer #(
  parameter int NUM_ENTRY  = 1024,
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_LEN   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_LEN-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  ram_we,
  output logic [ADDR_LEN-1:0]   ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_LEN-1:0]   ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]            state;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [7:0]            nh_q;
  logic [DATA_WIDTH-1:0] rmw_word;
  logic [31:0]           addr_ext;
  logic                  bad;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign addr_ext  = 32'(cmd_addr);

`ifdef STAGE_RAM_WRITER_CLEAR_EN
  logic [ADDR_LEN-1:0] clr_cnt, clr_next, end_q, cmd_end;
  logic [31:0]         end_ext;

  assign cmd_end  = cmd_data[ADDR_LEN-1:0];
  assign end_ext  = 32'(cmd_end);
  assign clr_next = clr_cnt + ADDR_LEN'(1);
  assign bad = (cmd_op == 2'b11) || (addr_ext >= 32'(NUM_ENTRY)) ||
               ((cmd_op == 2'b10) && ((end_ext >= 32'(NUM_ENTRY)) || (cmd_end < cmd_addr)));
`else
  assign bad = (cmd_op[1] == 1'b1) || (addr_ext >= 32'(NUM_ENTRY));
`endif

  // Merge keeps the stored next-stage index, forces exist and replaces nexthop.
  always_comb begin
    rmw_word = ram_rdata;
    rmw_word[DATA_WIDTH-1] = 1'b1;
    rmw_word[DATA_WIDTH-2 -: 8] = nh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      nh_q      <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_raddr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef STAGE_RAM_WRITER_CLEAR_EN
      clr_cnt   <= '0;
      end_q     <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            nh_q   <= cmd_data[7:0];
            if (bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              case (cmd_op)
                2'b00: begin
                  state     <= S_WR;
                  ram_we    <= 1'b1;
                  ram_waddr <= cmd_addr;
                  ram_wdata <= cmd_data;
                  done      <= 1'b1;
                end
                2'b01: begin
                  state     <= S_RD;
                  ram_raddr <= cmd_addr;
                end
`ifdef STAGE_RAM_WRITER_CLEAR_EN
                2'b10: begin
                  state     <= S_CLR;
                  ram_we    <= 1'b1;
                  ram_waddr <= cmd_addr;
                  ram_wdata <= '0;
                  clr_cnt   <= cmd_addr;
                  end_q     <= cmd_end;
                  done      <= (cmd_addr == cmd_end);
                end
`endif
                default: begin
                  state <= S_ERR;
                  err   <= 1'b1;
                end
              endcase
            end
          end
        end
        S_WR:  state <= S_IDLE;
        S_RD:  state <= S_RDW;
        S_RDW: begin
          state     <= S_WR;
          ram_we    <= 1'b1;
          ram_waddr <= addr_q;
          ram_wdata <= rmw_word;
          done      <= 1'b1;
        end
`ifdef STAGE_RAM_WRITER_CLEAR_EN
        S_CLR: begin
          if (clr_cnt == end_q) begin
            state <= S_IDLE;
          end else begin
            clr_cnt   <= clr_next;
            ram_we    <= 1'b1;
            ram_waddr <= clr_next;
            ram_wdata <= '0;
            done      <= (clr_next == end_q);
          end
        end
`endif
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ram_writer.sv
// Bench for stage_ram_writer: directed table, randomized commands vs a behavioural
// model, and reset-abort sequences. Follows STAGE_RAM_WRITER_CLEAR_EN like the RTL.
module tb_stage_ram_writer;
  localparam int NE = 1024;
  localparam int DW = 19;
  localparam int AL = 11;
`ifdef STAGE_RAM_WRITER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AL-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          ram_we;
  logic [AL-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AL-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          busy, done, err;

  stage_ram_writer #(.NUM_ENTRY(NE), .DATA_WIDTH(DW), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Stage memory as seen by the DUT: synchronous read, one cycle latency.
  logic [DW-1:0] ram [0:(1<<AL)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rdata <= ram[ram_raddr];
  end

  logic [DW-1:0] ref_mem [0:(1<<AL)-1];
  int checks = 0;
  int errors = 0;

  logic [AL-1:0] got_wa[$];
  logic [DW-1:0] got_wd[$];
  int            got_off[$], done_off[$], err_off[$];
  logic [AL-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];

  typedef struct {
    logic [1:0]    op;
    logic [AL-1:0] addr;
    logic [DW-1:0] data;
    bit            exp_err;
    int            exp_nwr;
    logic [DW-1:0] exp_wd;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected error, write list, first write offset and ready-return offset.
  task automatic model(input logic [1:0] op, input logic [AL-1:0] a, input logic [DW-1:0] d,
                       output bit e, output int first_off, output int rdy_off);
    int ai, en;
    ai = int'(a);
    en = int'(d[AL-1:0]);
    exp_wa.delete();
    exp_wd.delete();
    e = (op == 2'd3) || (ai >= NE) || (op == 2'd2 && (!CLR_EN || en >= NE || en < ai));
    first_off = 1;
    rdy_off   = 2;
    if (!e) begin
      case (op)
        2'd0: begin
          exp_wa.push_back(a); exp_wd.push_back(d); ref_mem[ai] = d;
        end
        2'd1: begin
          logic [DW-1:0] m;
          m = {1'b1, d[7:0], ref_mem[ai][9:0]};
          exp_wa.push_back(a); exp_wd.push_back(m); ref_mem[ai] = m;
          first_off = 3; rdy_off = 4;
        end
        default: begin
          for (int i = ai; i <= en; i++) begin
            exp_wa.push_back(AL'(i)); exp_wd.push_back('0); ref_mem[i] = '0;
          end
          rdy_off = en - ai + 2;
        end
      endcase
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AL-1:0] a,
                         input logic [DW-1:0] d, output int nwr, output logic [DW-1:0] last_wd,
                         output bit got_err);
    bit e;
    int first_off, rdy_off, rdy, n;
    logic [AL-1:0] raddr1;
    got_wa.delete(); got_wd.delete(); got_off.delete(); done_off.delete(); err_off.delete();
    for (int k = 0; k < 3000 && !cmd_ready; k++) @(negedge clk);
    chk({tag, " ready_before"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AL'($urandom); cmd_data = DW'($urandom);
    rdy = -1;
    raddr1 = ram_raddr;
    for (int k = 1; k < 3000; k++) begin
      if (ram_we) begin got_wa.push_back(ram_waddr); got_wd.push_back(ram_wdata); got_off.push_back(k); end
      if (done) done_off.push_back(k);
      if (err) err_off.push_back(k);
      if (cmd_ready) begin rdy = k; break; end
      @(negedge clk);
    end
    model(op, a, d, e, first_off, rdy_off);
    chk({tag, " err_cnt"}, err_off.size(), e ? 1 : 0);
    if (err_off.size() > 0) chk({tag, " err_off"}, err_off[0], 1);
    chk({tag, " nwr"}, got_wa.size(), exp_wa.size());
    n = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s waddr[%0d]", tag, i), got_wa[i], exp_wa[i]);
      chk($sformatf("%s wdata[%0d]", tag, i), got_wd[i], exp_wd[i]);
      chk($sformatf("%s woff[%0d]", tag, i), got_off[i], first_off + i);
    end
    chk({tag, " done_cnt"}, done_off.size(), e ? 0 : 1);
    if (done_off.size() > 0 && !e) chk({tag, " done_off"}, done_off[0], first_off + exp_wa.size() - 1);
    chk({tag, " ready_off"}, rdy, rdy_off);
    if (op == 2'd1 && !e) chk({tag, " raddr"}, raddr1, a);
    nwr = got_wa.size();
    last_wd = (nwr > 0) ? got_wd[nwr-1] : '0;
    got_err = (err_off.size() > 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    logic [DW-1:0] lwd;
    bit gerr;
    bit saw_done;
    for (int i = 0; i < (1<<AL); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    tbl[0]  = '{2'd0, 11'd3,    19'h5A5A5, 1'b0, 1, 19'h5A5A5};
    tbl[1]  = '{2'd0, 11'd7,    19'h002A3, 1'b0, 1, 19'h002A3};
    tbl[2]  = '{2'd1, 11'd7,    19'h000C4, 1'b0, 1, 19'h712A3};
    tbl[3]  = '{2'd3, 11'd1,    19'h00000, 1'b1, 0, 19'h0};
    tbl[4]  = '{2'd0, 11'd1024, 19'h11111, 1'b1, 0, 19'h0};
    tbl[5]  = '{2'd2, 11'd9,    19'h00002, 1'b1, 0, 19'h0};
    tbl[6]  = '{2'd2, 11'd4,    19'h00007, !CLR_EN, CLR_EN ? 4 : 0, 19'h0};
    tbl[7]  = '{2'd2, 11'd8,    19'h00008, !CLR_EN, CLR_EN ? 1 : 0, 19'h0};
    tbl[8]  = '{2'd1, 11'd4,    19'h7FF5B, 1'b0, 1, 19'h56C00};
    tbl[9]  = '{2'd2, 11'd0,    19'h00400, 1'b1, 0, 19'h0};
    tbl[10] = '{2'd0, 11'd1023, 19'h7FFFF, 1'b0, 1, 19'h7FFFF};
    tbl[11] = '{2'd2, 11'd1023, 19'h003FF, !CLR_EN, CLR_EN ? 1 : 0, 19'h0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ram_we", ram_we, 1'b0);
    chk("rst ram_waddr", ram_waddr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    chk("rst ram_raddr", ram_raddr, 0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data, nwr, lwd, gerr);
      chk($sformatf("vec%0d tbl_err", i), gerr, tbl[i].exp_err);
      chk($sformatf("vec%0d tbl_nwr", i), nwr, tbl[i].exp_nwr);
      chk($sformatf("vec%0d tbl_wdata", i), lwd, tbl[i].exp_wd);
    end

    // Abort an in-flight command with reset; memory must keep exactly what was written before.
    run_cmd("pre9", 2'd0, 11'd9, 19'h12345, nwr, lwd, gerr);
    while (!cmd_ready) @(negedge clk);
    saw_done = 1'b0;
`ifdef STAGE_RAM_WRITER_CLEAR_EN
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 11'd0; cmd_data = 19'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && !(ram_we && ram_waddr == 11'd5); k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort reached addr5", ram_we && ram_waddr == 11'd5, 1'b1);
    for (int i = 0; i < 5; i++) ref_mem[i] = '0;
`else
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 11'd9; cmd_data = 19'h000AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
`endif
    if (done) saw_done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort ram_we", ram_we, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort ready", cmd_ready, 1'b1);
    chk("abort done", done, 1'b0);
    chk("abort done_seen", saw_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort ram9", ram[9], ref_mem[9]);
    chk("abort ram7", ram[7], ref_mem[7]);
    chk("abort ram3", ram[3], ref_mem[3]);
    chk("abort ram5", ram[5], ref_mem[5]);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [AL-1:0] a;
      logic [DW-1:0] d;
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? AL'(1024 + $urandom_range(0, 1023)) : AL'($urandom_range(0, 1023));
      d = DW'($urandom);
      if (op == 2'd2) begin
        if ($urandom_range(0, 7) == 0 && a > 0) d[AL-1:0] = a - AL'(1);
        else d[AL-1:0] = a + AL'($urandom_range(0, 6));
      end
      run_cmd($sformatf("rnd%0d", i), op, a, d, nwr, lwd, gerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_ram_writer.md
# stage_ram_writer

Update engine for one pipeline stage of the 4-bit trie lookup. It accepts rule-update commands over a valid/ready handshake and drives the write port of that stage's dual-port rule memory. Entries use the stage format: exist bit, then 8-bit nexthop, then next-stage block index. The engine supports three operations: a full-entry write, a nexthop read-modify-write, and a ranged clear. It sits between the control-plane update path and each stage memory, while the lookup pipeline keeps the read side.

## Interface
- NUM_ENTRY, 1024, stage memory height in entries
- DATA_WIDTH, 19, entry width: exist[DATA_WIDTH-1], nexthop[DATA_WIDTH-2:DATA_WIDTH-9], next-stage index in the remaining LSBs
- ADDR_LEN, 10, address width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept; high only in IDLE
- cmd_op  in  2  00 write entry, 01 set nexthop, 10 clear range, 11 reserved
- cmd_addr  in  ADDR_LEN  target address, or range start for op 10
- cmd_data  in  DATA_WIDTH  op 00: full entry; op 01: [7:0] nexthop; op 10: [ADDR_LEN-1:0] inclusive end address
- ram_we  out  1  write enable, registered
- ram_waddr  out  ADDR_LEN  write address, registered
- ram_wdata  out  DATA_WIDTH  write data, registered
- ram_raddr  out  ADDR_LEN  read address for RMW, registered
- ram_rdata  in  DATA_WIDTH  memory read data, valid one cycle after ram_raddr
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with the final ram_we of a command
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- **States:** IDLE, WR, RD, RDW, CLR, ERR.
- **Accept:** a command is accepted on any edge with cmd_valid && cmd_ready. On accept, op, addr and data are registered.
- **Validation:** an accepted command goes to ERR if any of these holds:
  - cmd_op is 11;
  - cmd_addr ≥ NUM_ENTRY;
  - for op 10, end ≥ NUM_ENTRY or end < start.
- **ERR:** err is high for one cycle, no memory write occurs, then the FSM returns to IDLE.
- **op 00 (IDLE→WR→IDLE):** ram_we=1, ram_waddr=addr, ram_wdata=cmd_data; done pulses.
- **op 01 (IDLE→RD→RDW→WR→IDLE):**
  - RD drives ram_raddr=addr.
  - RDW samples ram_rdata and merges it: exist=1, nexthop=data[7:0], next-stage index preserved.
  - WR writes the merged word; done pulses.
- **op 10 (IDLE→CLR→IDLE):**
  - Writes all-zero words, one per cycle, from start to end inclusive, using an ADDR_LEN-bit counter.
  - done pulses with the write to end.
  - start==end produces exactly one write.
- **Serialisation:** commands are strictly serialised. An RMW therefore always reads data that reflects every earlier command's write.
- **Reset:** rst_n low at any time forces IDLE and clears all outputs. An in-progress command is abandoned; a partial clear stays partial.

## Timing
- **Reset values:** ram_we=0, ram_waddr=0, ram_wdata=0, ram_raddr=0, busy=0, done=0, err=0, cmd_ready=1.
- **Latency from the accept edge at cycle T:**
  - op 00: write in cycle T+1.
  - op 01: read address in T+1, data sampled in T+2, write in T+3.
  - op 10: writes in T+1 … T+1+(end−start).
  - rejected command: err in T+1.
- **Ready:** cmd_ready drops in T+1 and returns in the cycle after the last busy cycle.
- **Throughput:** op 00 sustains at most one command every 2 cycles.
- **Unused outputs:** outside RD, ram_raddr holds its last value. Outside write cycles, ram_we=0 and ram_waddr/ram_wdata hold their last values.

## Configuration
- **STAGE_RAM_WRITER_CLEAR_EN defined:** op 10 is implemented as above.
- **STAGE_RAM_WRITER_CLEAR_EN undefined:**
  - CLR state and range counter are not synthesised.
  - op 10 is treated like op 11: ERR, err pulse, no write.

## Test plan
- Reset held, then released: all outputs at reset values and cmd_ready=1. Pulse rst_n low mid-clear at address 5 of range 0–9: ram_we=0 immediately, IDLE, no done.
- op 00, addr 3, data 19'h5A5A5: ram_we=1 at T+1 with waddr=3 and wdata=19'h5A5A5; done at T+1; cmd_ready=1 at T+2.
- Preload addr 7 = 19'h0_00_2A3 in the memory model; op 01, addr 7, data[7:0]=8'hC4: raddr=7 at T+1; write at T+3 of {1'b1, 8'hC4, 10'h2A3}.
- op 10, start 4, end 7 (macro on): zero writes to 4,5,6,7 in T+1..T+4; done only at T+4. Range 8→8 gives a single write.
- Rejects: op 11, addr 1024, and clear 9→2 each give err at T+1 and no ram_we. With the macro off, op 10 also gives err.
- Back-to-back: op 00 to addr 7 followed immediately by op 01 to addr 7. The RMW must read the freshly written value and preserve its next-stage index.
